// File: rtl/wtch_pkg.sv
// wtch_pkg: field limits, widths and the wrap helper shared by the watch datapath, FND formatter and UART reporter.
// WTCH_12H_EN selects 12-hour limits (hour 1..12, reset 12).
package wtch_pkg;

    localparam int unsigned CSEC_W = 7;
    localparam int unsigned SEC_W  = 6;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned HOUR_W = 5;

    localparam int unsigned CSEC_MAX = 99;
    localparam int unsigned SEC_MAX  = 59;
    localparam int unsigned MIN_MAX  = 59;
`ifdef WTCH_12H_EN
    localparam int unsigned HOUR_MAX = 12;
    localparam int unsigned HOUR_MIN = 1;
    localparam int unsigned HOUR_RST = 12;
`else
    localparam int unsigned HOUR_MAX = 23;
    localparam int unsigned HOUR_MIN = 0;
    localparam int unsigned HOUR_RST = 0;
`endif

    typedef enum logic {
        SEL_HOUR = 1'b0,
        SEL_MIN  = 1'b1
    } calib_sel_e;

    // Modular +1/-1 inside [lo, hi]; shared by tick carries and calibration.
    function automatic logic [7:0] wrap_step(input logic [7:0] val, input logic [7:0] lo,
                                             input logic [7:0] hi, input logic inc);
        logic [7:0] r;
        if (inc) r = (val == hi) ? lo : val + 8'd1;
        else     r = (val == lo) ? hi : val - 8'd1;
        return r;
    endfunction

endpackage

// File: rtl/wtch_datapath_if.sv
// wtch_datapath_if: controller-to-datapath levels/pulses and the registered time fields.
// WTCH_12H_EN adds the pm flag to both modports.
interface wtch_datapath_if;
    logic                          run;
    logic                          up;
    logic                          dn;
    logic                          calib_right;
    logic [wtch_pkg::CSEC_W-1:0]   csec;
    logic [wtch_pkg::SEC_W-1:0]    sec;
    logic [wtch_pkg::MIN_W-1:0]    min;
    logic [wtch_pkg::HOUR_W-1:0]   hour;
    logic                          tick;
`ifdef WTCH_12H_EN
    logic                          pm;

    modport master (output run, up, dn, calib_right, input csec, sec, min, hour, tick, pm);
    modport slave  (input run, up, dn, calib_right, output csec, sec, min, hour, tick, pm);
`else
    modport master (output run, up, dn, calib_right, input csec, sec, min, hour, tick);
    modport slave  (input run, up, dn, calib_right, output csec, sec, min, hour, tick);
`endif
endinterface

// File: rtl/wtch_tick_gen.sv
// wtch_tick_gen: divide-by-DIV prescaler; the count freezes while en is low so no partial period is lost.
module wtch_tick_gen #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (en) cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/wtch_datapath.sv
// wtch_datapath: prescaled csec/sec/min/hour chain with min/hour calibration while paused.
// Define WTCH_12H_EN for 12-hour mode (hour 1..12) and the pm flag.
module wtch_datapath
    import wtch_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TICK_HZ = 100
) (
    input  logic           clk,
    input  logic           rst,
    wtch_datapath_if.slave io
);
    localparam int unsigned DIV = CLK_HZ / TICK_HZ;

    logic              tick_en;
    logic              tick_q;
    logic [CSEC_W-1:0] csec_q, csec_d;
    logic [SEC_W-1:0]  sec_q,  sec_d;
    logic [MIN_W-1:0]  min_q,  min_d;
    logic [HOUR_W-1:0] hour_q, hour_d;
    logic              csec_wrap, sec_wrap, min_wrap;
    logic              calib_step;
    calib_sel_e        sel;
`ifdef WTCH_12H_EN
    logic              pm_q, pm_d;
`endif

    wtch_tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (io.run),
        .tick (tick_en)
    );

    assign csec_wrap  = (csec_q == CSEC_W'(CSEC_MAX));
    assign sec_wrap   = (sec_q  == SEC_W'(SEC_MAX));
    assign min_wrap   = (min_q  == MIN_W'(MIN_MAX));
    assign sel        = calib_sel_e'(io.calib_right);
    assign calib_step = !io.run && (io.up != io.dn);

    // tick_en implies run=1, so the tick chain and calibration never compete.
    always_comb begin
        csec_d = csec_q;
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
`ifdef WTCH_12H_EN
        pm_d   = pm_q;
`endif
        if (tick_en) begin
            csec_d = CSEC_W'(wrap_step(8'(csec_q), 8'd0, 8'(CSEC_MAX), 1'b1));
            if (csec_wrap) begin
                sec_d = SEC_W'(wrap_step(8'(sec_q), 8'd0, 8'(SEC_MAX), 1'b1));
                if (sec_wrap) begin
                    min_d = MIN_W'(wrap_step(8'(min_q), 8'd0, 8'(MIN_MAX), 1'b1));
                    if (min_wrap) begin
                        hour_d = HOUR_W'(wrap_step(8'(hour_q), 8'(HOUR_MIN), 8'(HOUR_MAX), 1'b1));
`ifdef WTCH_12H_EN
                        if (hour_q == HOUR_W'(11)) pm_d = !pm_q;
`endif
                    end
                end
            end
        end else if (calib_step) begin
            if (sel == SEL_MIN) min_d  = MIN_W'(wrap_step(8'(min_q), 8'd0, 8'(MIN_MAX), io.up));
            else                hour_d = HOUR_W'(wrap_step(8'(hour_q), 8'(HOUR_MIN), 8'(HOUR_MAX), io.up));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csec_q <= '0;
            sec_q  <= '0;
            min_q  <= '0;
            hour_q <= HOUR_W'(HOUR_RST);
            tick_q <= 1'b0;
`ifdef WTCH_12H_EN
            pm_q   <= 1'b0;
`endif
        end else begin
            csec_q <= csec_d;
            sec_q  <= sec_d;
            min_q  <= min_d;
            hour_q <= hour_d;
            tick_q <= tick_en;
`ifdef WTCH_12H_EN
            pm_q   <= pm_d;
`endif
        end
    end

    assign io.csec = csec_q;
    assign io.sec  = sec_q;
    assign io.min  = min_q;
    assign io.hour = hour_q;
    assign io.tick = tick_q;
`ifdef WTCH_12H_EN
    assign io.pm   = pm_q;
`endif
endmodule

// File: tb/tb_wtch_datapath.sv
// tb_wtch_datapath: randomized and directed stimulus checked against a time-of-day model held as total centiseconds.
module tb_wtch_datapath;
    localparam int DIV     = 10;
    localparam int HOUR_CS = 360000;
`ifdef WTCH_12H_EN
    localparam int NH = 12;
`else
    localparam int NH = 24;
`endif

    logic clk;
    logic rst;

    wtch_datapath_if bus();

    wtch_datapath #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Model: centiseconds since the start of the hour cycle, run-cycle phase, last tick, pm.
    int m_t;
    int m_pre;
    bit m_tick;
    bit m_pm;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int f_cs();  return m_t % 100;           endfunction
    function automatic int f_s();   return (m_t / 100) % 60;    endfunction
    function automatic int f_m();   return (m_t / 6000) % 60;   endfunction
    function automatic int f_h();   return m_t / HOUR_CS;       endfunction
    function automatic int hdisp(input int h); return (NH == 12 && h == 0) ? 12 : h; endfunction

    task automatic model_reset();
        m_t = 0; m_pre = 0; m_tick = 0; m_pm = 0;
    endtask

    task automatic compare_all(input string pfx);
        check_eq({pfx, ".csec"}, int'(bus.csec), f_cs());
        check_eq({pfx, ".sec"},  int'(bus.sec),  f_s());
        check_eq({pfx, ".min"},  int'(bus.min),  f_m());
        check_eq({pfx, ".hour"}, int'(bus.hour), hdisp(f_h()));
        check_eq({pfx, ".tick"}, int'(bus.tick), int'(m_tick));
`ifdef WTCH_12H_EN
        check_eq({pfx, ".pm"},   int'(bus.pm),   int'(m_pm));
`endif
    endtask

    // One clock cycle: drive on the falling edge, update the model at the rising edge, compare 1 ns later.
    task automatic cyc(input bit r, input bit u, input bit d, input bit cr);
        int old, step;
        @(negedge clk);
        bus.run = r; bus.up = u; bus.dn = d; bus.calib_right = cr;
        @(posedge clk);
        m_tick = 0;
        if (r) begin
            if (m_pre == DIV - 1) begin
                m_pre  = 0;
                m_tick = 1;
                m_t++;
                if (m_t == NH * HOUR_CS) begin
                    m_t  = 0;
                    m_pm = !m_pm;
                end
            end else begin
                m_pre++;
            end
        end else if (u != d) begin
            step = u ? 1 : -1;
            if (cr) begin
                old = f_m();
                m_t += (((old + step + 60) % 60) - old) * 6000;
            end else begin
                old = f_h();
                m_t += (((old + step + NH) % NH) - old) * HOUR_CS;
            end
        end
        #1 compare_all("cyc");
    endtask

    // Drop reset between clock edges; outputs must clear before the next edge.
    task automatic async_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        model_reset();
        compare_all("arst");
        @(negedge clk);
        bus.run = 0; bus.up = 0; bus.dn = 0; bus.calib_right = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic tick_latency(input string tag, input int exp);
        int k;
        k = 0;
        do begin
            cyc(1, 0, 0, 0);
            k++;
        end while (!bus.tick && k < 40);
        check_eq(tag, k, exp);
    endtask

    initial begin
        int guard;
        rst = 1'b1;
        bus.run = 0; bus.up = 0; bus.dn = 0; bus.calib_right = 0;
        model_reset();
        #3 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 compare_all("rst");
        @(negedge clk);
        rst = 1'b1;

        // Free run: first tick after DIV run cycles, 100 ticks roll into seconds.
        tick_latency("first_tick_lat", DIV);
        repeat (DIV * 100 - DIV) cyc(1, 0, 0, 0);
        check_eq("free_sec", int'(bus.sec), 1);
        check_eq("free_csec", int'(bus.csec), 0);

        // Pause/resume keeps the partial prescaler count.
        repeat (7) cyc(1, 0, 0, 0);
        repeat (50) cyc(0, 0, 0, 0);
        tick_latency("resume_lat", 3);

        // Calibration wraps without carry.
        async_reset();
        cyc(0, 0, 1, 1);
        check_eq("cal_min_dn", int'(bus.min), 59);
        check_eq("cal_min_hour_kept", int'(bus.hour), hdisp(0));
        cyc(0, 0, 1, 0);
        check_eq("cal_hour_dn", int'(bus.hour), hdisp(NH - 1));
        cyc(0, 1, 0, 0);
        check_eq("cal_hour_up_wrap", int'(bus.hour), hdisp(0));
        cyc(0, 1, 1, 1);
        check_eq("cal_both", int'(bus.min), 59);
        cyc(1, 1, 0, 1);
        check_eq("cal_run_ignored", int'(bus.min), 59);

        // Randomized mix of run levels and calibration pulses.
        repeat (3000)
            cyc($urandom_range(0, 1), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                $urandom_range(0, 1));

        // Reset mid-count restarts the prescaler with its full period.
        repeat (4) cyc(1, 0, 0, 0);
        async_reset();
        tick_latency("arst_tick_lat", DIV);

        // Full roll-over from the last hour, minute 59, second 59.99.
        guard = 0;
        while (f_h() != NH - 1 && guard < 30) begin cyc(0, 0, 1, 0); guard++; end
        guard = 0;
        while (f_m() != 59 && guard < 70) begin cyc(0, 0, 1, 1); guard++; end
        guard = 0;
        while (!(f_s() == 59 && f_cs() == 99) && guard < 70000) begin cyc(1, 0, 0, 0); guard++; end
        check_eq("roll_pre_hour", int'(bus.hour), hdisp(NH - 1));
        tick_latency("roll_tick_lat", DIV);
        check_eq("roll_csec", int'(bus.csec), 0);
        check_eq("roll_sec", int'(bus.sec), 0);
        check_eq("roll_min", int'(bus.min), 0);
        check_eq("roll_hour", int'(bus.hour), hdisp(0));
`ifdef WTCH_12H_EN
        check_eq("roll_pm", int'(bus.pm), 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
